// File: rtl/match_controller_if.sv
// match_controller_if
//   Groups the match sequencer's event inputs and scoreboard/board-control
//   outputs into one bundle.
//   master : environment side (win detector, key debouncer, board memory)
//   slave  : match_controller side
//   Signals:
//     winG, winR, draw, newMatch : single-cycle event pulses into the sequencer
//     clearAck                   : board memory finished clearing (level)
//     scoreG, scoreR             : round wins per player
//     playEn                     : board accepts moves
//     clearReq                   : board clear request, held until acknowledged
//     matchOver                  : a player reached the winning score
//     winner                     : 00 none, 01 green, 10 red
interface match_controller_if #(
  parameter int SCORE_W = 3
);
  logic               winG;
  logic               winR;
  logic               draw;
  logic               newMatch;
  logic               clearAck;
  logic [SCORE_W-1:0] scoreG;
  logic [SCORE_W-1:0] scoreR;
  logic               playEn;
  logic               clearReq;
  logic               matchOver;
  logic [1:0]         winner;

  modport master (
    output winG, winR, draw, newMatch, clearAck,
    input  scoreG, scoreR, playEn, clearReq, matchOver, winner
  );

  modport slave (
    input  winG, winR, draw, newMatch, clearAck,
    output scoreG, scoreR, playEn, clearReq, matchOver, winner
  );
endinterface

// File: rtl/match_controller.sv
// match_controller
//   Match sequencer for the 16x16 Connect Four game. Keeps the green/red
//   round scores, gates move entry, requests a board clear between rounds
//   and declares the match over once a player reaches WIN_SCORE.
//   Ports:
//     clk  : system clock, all state changes on its rising edge
//     RST  : synchronous active-low reset
//     bus  : match_controller_if.slave (events in, scores/control out)
//   Parameters:
//     WIN_SCORE   : round wins needed to take the match (fits in SCORE_W)
//     SCORE_W     : score width
//     HOLD_CYCLES : cycles the finished board stays visible (>= 1)
module match_controller #(
  parameter int WIN_SCORE   = 5,
  parameter int SCORE_W     = 3,
  parameter int HOLD_CYCLES = 3
) (
  input  logic                clk,
  input  logic                RST,
  match_controller_if.slave   bus
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [SCORE_W-1:0] WIN_S    = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_ONE = HOLD_W'(1);

  typedef enum logic [2:0] {
    S_INIT,
    S_CLEAR,
    S_PLAY,
    S_ROUND_END,
    S_MATCH_OVER
  } state_t;

  state_t             state, state_nxt;
  logic [SCORE_W-1:0] score_g, score_g_nxt;
  logic [SCORE_W-1:0] score_r, score_r_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_nxt;
  logic [1:0]         winner_q, winner_nxt;

  // Saturating round-win increment; PLAY is unreachable at WIN_SCORE, so the
  // clamp only guards against an unexpected path.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN_S) ? WIN_S : s + 1'b1;
  endfunction

  // State / score registers
  always_ff @(posedge clk) begin
    if (!RST) begin
      state    <= S_INIT;
      score_g  <= '0;
      score_r  <= '0;
      hold_cnt <= '0;
      winner_q <= 2'b00;
    end else begin
      state    <= state_nxt;
      score_g  <= score_g_nxt;
      score_r  <= score_r_nxt;
      hold_cnt <= hold_cnt_nxt;
      winner_q <= winner_nxt;
    end
  end

  // Next-state and score update
  always_comb begin
    state_nxt    = state;
    score_g_nxt  = score_g;
    score_r_nxt  = score_r;
    hold_cnt_nxt = hold_cnt;
    winner_nxt   = winner_q;
    case (state)
      S_INIT: state_nxt = S_CLEAR;
      S_CLEAR: begin
        if (bus.clearAck) state_nxt = S_PLAY;
      end
      S_PLAY: begin
        // Abort beats any same-cycle round result.
        if (bus.newMatch) begin
          score_g_nxt = '0;
          score_r_nxt = '0;
          winner_nxt  = 2'b00;
          state_nxt   = S_CLEAR;
        end else if (bus.winG || bus.winR || bus.draw) begin
          // A lone win scores even if draw fires with it; a double win is a tie.
          if (bus.winG && !bus.winR) score_g_nxt = sat_inc(score_g);
          if (bus.winR && !bus.winG) score_r_nxt = sat_inc(score_r);
          hold_cnt_nxt = HOLD_ONE;
          state_nxt    = S_ROUND_END;
        end
      end
      S_ROUND_END: begin
        if (hold_cnt >= HOLD_MAX) begin
          hold_cnt_nxt = '0;
          if (score_g == WIN_S) begin
            winner_nxt = 2'b01;
            state_nxt  = S_MATCH_OVER;
          end else if (score_r == WIN_S) begin
            winner_nxt = 2'b10;
            state_nxt  = S_MATCH_OVER;
          end else begin
            state_nxt  = S_CLEAR;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      S_MATCH_OVER: begin
        if (bus.newMatch) begin
          score_g_nxt = '0;
          score_r_nxt = '0;
          winner_nxt  = 2'b00;
          state_nxt   = S_CLEAR;
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Outputs decoded from registers only
  assign bus.scoreG    = score_g;
  assign bus.scoreR    = score_r;
  assign bus.winner    = winner_q;
  assign bus.playEn    = (state == S_PLAY);
  assign bus.clearReq  = (state == S_CLEAR);
  assign bus.matchOver = (state == S_MATCH_OVER);

  a_score_sat: assert property (@(posedge clk) disable iff (!RST)
    (score_g <= WIN_S) && (score_r <= WIN_S));

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller
//   Bench for match_controller with WIN_SCORE=5, HOLD_CYCLES=3. Directed
//   scenario tasks plus a randomized round sequence checked against a
//   round-level score model (one update per round outcome).
module tb_match_controller;

  localparam int WIN  = 5;
  localparam int HOLD = 3;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic RST = 1'b0;

  match_controller_if #(.SCORE_W(3)) bus ();

  match_controller #(
    .WIN_SCORE(WIN),
    .SCORE_W(3),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  // Observed output vector: {scoreG, scoreR, playEn, clearReq, matchOver, winner}
  function automatic logic [10:0] obs();
    return {bus.scoreG, bus.scoreR, bus.playEn, bus.clearReq, bus.matchOver, bus.winner};
  endfunction

  function automatic logic [10:0] ev(input int g, input int r, input bit p,
                                     input bit c, input bit m, input logic [1:0] w);
    return {3'(g), 3'(r), p, c, m, w};
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge and
  // event pulses are withdrawn so each lasts exactly one cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.winG     = 1'b0;
    bus.winR     = 1'b0;
    bus.draw     = 1'b0;
    bus.newMatch = 1'b0;
  endtask

  task automatic noise(input bit allow_new);
    bus.winG     = 1'($urandom_range(0, 1));
    bus.winR     = 1'($urandom_range(0, 1));
    bus.draw     = 1'($urandom_range(0, 1));
    bus.newMatch = allow_new ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // Reset and bring the controller to PLAY with clearAck high.
  task automatic do_reset();
    bus.clearAck = 1'b1;
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    bus.clearAck = 1'b1;
    RST = 1'b0;
    tick();
    tick();
    exp = ev(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL reset_outputs: got %b expected %b", obs(), exp); end
    RST = 1'b1;
    #1;
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL init_cycle: got %b expected %b", obs(), exp); end
    tick();
    exp = ev(0, 0, 0, 1, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL startup_clear: got %b expected %b", obs(), exp); end
    tick();
    exp = ev(0, 0, 1, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL startup_play: got %b expected %b", obs(), exp); end
  endtask

  task automatic test_single_round();
    logic [10:0] exp;
    do_reset();
    bus.winG = 1'b1;
    tick();
    exp = ev(1, 0, 0, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL round_score: got %b expected %b", obs(), exp); end
    for (int i = 0; i < HOLD - 1; i++) begin
      tick();
      checks++;
      if (obs() !== exp) begin errors++; $display("FAIL round_hold: got %b expected %b", obs(), exp); end
    end
    tick();
    exp = ev(1, 0, 0, 1, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL round_clear: got %b expected %b", obs(), exp); end
    tick();
    exp = ev(1, 0, 1, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL round_replay: got %b expected %b", obs(), exp); end
  endtask

  task automatic test_match_win();
    logic [10:0] exp;
    do_reset();
    for (int k = 1; k <= WIN; k++) begin
      bus.winR = 1'b1;
      tick();
      exp = ev(0, k, 0, 0, 0, 2'b00);
      checks++;
      if (obs() !== exp) begin errors++; $display("FAIL match_score: got %b expected %b", obs(), exp); end
      repeat (HOLD - 1) tick();
      tick();
      if (k < WIN) begin
        exp = ev(0, k, 0, 1, 0, 2'b00);
        checks++;
        if (obs() !== exp) begin errors++; $display("FAIL match_clear: got %b expected %b", obs(), exp); end
        tick();
      end else begin
        exp = ev(0, WIN, 0, 0, 1, 2'b10);
        checks++;
        if (obs() !== exp) begin errors++; $display("FAIL match_over: got %b expected %b", obs(), exp); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) bus.winR = 1'b1;
      else            bus.draw = 1'b1;
      tick();
      exp = ev(0, WIN, 0, 0, 1, 2'b10);
      checks++;
      if (obs() !== exp) begin errors++; $display("FAIL match_saturate: got %b expected %b", obs(), exp); end
    end
  endtask

  task automatic test_simultaneous();
    logic [10:0] exp;
    do_reset();
    bus.winG = 1'b1;
    bus.winR = 1'b1;
    tick();
    exp = ev(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL both_wins: got %b expected %b", obs(), exp); end
    repeat (HOLD + 1) tick();
    exp = ev(0, 0, 1, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL both_replay: got %b expected %b", obs(), exp); end
    bus.winG = 1'b1;
    bus.draw = 1'b1;
    tick();
    exp = ev(1, 0, 0, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL win_draw: got %b expected %b", obs(), exp); end
    repeat (HOLD + 1) tick();
    exp = ev(1, 0, 1, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL win_draw_replay: got %b expected %b", obs(), exp); end
    bus.newMatch = 1'b1;
    bus.winG     = 1'b1;
    tick();
    exp = ev(0, 0, 0, 1, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL newmatch_priority: got %b expected %b", obs(), exp); end
    tick();
    exp = ev(0, 0, 1, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL newmatch_replay: got %b expected %b", obs(), exp); end
  endtask

  task automatic test_handshake_stall();
    logic [10:0] exp;
    do_reset();
    bus.winG = 1'b1;
    tick();
    repeat (HOLD - 1) tick();
    bus.clearAck = 1'b0;
    tick();
    exp = ev(1, 0, 0, 1, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL stall_entry: got %b expected %b", obs(), exp); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs() !== exp) begin errors++; $display("FAIL stall_hold: got %b expected %b", obs(), exp); end
    end
    bus.clearAck = 1'b1;
    tick();
    exp = ev(1, 0, 1, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL stall_release: got %b expected %b", obs(), exp); end
  endtask

  task automatic test_restart();
    logic [10:0] exp;
    logic [7:0]  seq;
    seq = 8'b00011111;  // bit i: 1 = green win, 0 = red win, applied LSB last
    do_reset();
    for (int i = 7; i >= 0; i--) begin
      if (seq[i]) bus.winG = 1'b1;
      else        bus.winR = 1'b1;
      tick();
      repeat (HOLD + 1) tick();
    end
    exp = ev(5, 3, 0, 0, 1, 2'b01);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL restart_matchover: got %b expected %b", obs(), exp); end
    bus.newMatch = 1'b1;
    tick();
    exp = ev(0, 0, 0, 1, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL restart_clear: got %b expected %b", obs(), exp); end
    tick();
    bus.winG = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    exp = ev(0, 0, 0, 0, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL midreset: got %b expected %b", obs(), exp); end
    RST = 1'b1;
    tick();
    exp = ev(0, 0, 0, 1, 0, 2'b00);
    checks++;
    if (obs() !== exp) begin errors++; $display("FAIL midreset_recover: got %b expected %b", obs(), exp); end
    tick();
  endtask

  // Randomized rounds against a round-level score model.
  task automatic test_random();
    logic [10:0] exp;
    logic [1:0]  w;
    int g, r, oc, stall;
    bit wg, wr;
    do_reset();
    g = 0;
    r = 0;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        exp = ev(g, r, 1, 0, 0, 2'b00);
        checks++;
        if (obs() !== exp) begin errors++; $display("FAIL rand_idle: got %b expected %b", obs(), exp); end
      end
      oc = int'($urandom_range(0, 6));
      wg = (oc == 0) || (oc == 2) || (oc == 4);
      wr = (oc == 1) || (oc == 2) || (oc == 5);
      bus.winG = wg;
      bus.winR = wr;
      bus.draw = (oc >= 3);
      if (oc == 6) begin
        bus.newMatch = 1'b1;
        bus.winG     = 1'($urandom_range(0, 1));
        tick();
        g = 0;
        r = 0;
        exp = ev(0, 0, 0, 1, 0, 2'b00);
        checks++;
        if (obs() !== exp) begin errors++; $display("FAIL rand_abort: got %b expected %b", obs(), exp); end
      end else begin
        tick();
        if (wg && !wr && g < WIN) g = g + 1;
        if (wr && !wg && r < WIN) r = r + 1;
        exp = ev(g, r, 0, 0, 0, 2'b00);
        checks++;
        if (obs() !== exp) begin errors++; $display("FAIL rand_round: got %b expected %b", obs(), exp); end
        repeat (HOLD - 1) begin
          noise(1'b1);
          tick();
          checks++;
          if (obs() !== exp) begin errors++; $display("FAIL rand_hold: got %b expected %b", obs(), exp); end
        end
        noise(1'b1);
        tick();
        if (g == WIN || r == WIN) begin
          w = (g == WIN) ? 2'b01 : 2'b10;
          exp = ev(g, r, 0, 0, 1, w);
          checks++;
          if (obs() !== exp) begin errors++; $display("FAIL rand_matchover: got %b expected %b", obs(), exp); end
          repeat ($urandom_range(0, 2)) begin
            noise(1'b0);
            tick();
            checks++;
            if (obs() !== exp) begin errors++; $display("FAIL rand_mo_hold: got %b expected %b", obs(), exp); end
          end
          bus.newMatch = 1'b1;
          tick();
          g = 0;
          r = 0;
          exp = ev(0, 0, 0, 1, 0, 2'b00);
          checks++;
          if (obs() !== exp) begin errors++; $display("FAIL rand_restart: got %b expected %b", obs(), exp); end
        end else begin
          exp = ev(g, r, 0, 1, 0, 2'b00);
          checks++;
          if (obs() !== exp) begin errors++; $display("FAIL rand_clear: got %b expected %b", obs(), exp); end
        end
      end
      stall = int'($urandom_range(0, 3));
      if (stall > 0) begin
        bus.clearAck = 1'b0;
        repeat (stall) begin
          noise(1'b1);
          tick();
          exp = ev(g, r, 0, 1, 0, 2'b00);
          checks++;
          if (obs() !== exp) begin errors++; $display("FAIL rand_stall: got %b expected %b", obs(), exp); end
        end
        bus.clearAck = 1'b1;
      end
      tick();
      exp = ev(g, r, 1, 0, 0, 2'b00);
      checks++;
      if (obs() !== exp) begin errors++; $display("FAIL rand_play: got %b expected %b", obs(), exp); end
    end
  endtask

  initial begin
    bus.winG     = 1'b0;
    bus.winR     = 1'b0;
    bus.draw     = 1'b0;
    bus.newMatch = 1'b0;
    bus.clearAck = 1'b1;
    test_reset();
    test_single_round();
    test_match_win();
    test_simultaneous();
    test_handshake_stall();
    test_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
